// File: rtl/alu_pkg.sv
// Shared decode definitions for the alu_issue stage: opcodes, ALU op encodings,
// instruction field positions and the OP/OP-IMM decode helper.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;
  localparam int IMM_LSB = 20;
  localparam int IMM_MSB = 31;
  localparam int ALT_BIT = 30;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    logic        legal;
    logic        reads_rs2;
    logic [3:0]  op;
    reg_addr_t   rd;
    reg_addr_t   rs1;
    reg_addr_t   rs2;
    logic [31:0] imm;
  } dec_t;

  function automatic logic [3:0] alu_op_of(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Only funct7 = 0 is legal, except 0100000 on the add/sub and shift-right slots.
  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3          = instr[F3_MSB:F3_LSB];
    f7          = instr[F7_MSB:F7_LSB];
    d.legal     = 1'b0;
    d.reads_rs2 = 1'b0;
    d.op        = ALU_ADD;
    d.rd        = instr[RD_MSB:RD_LSB];
    d.rs1       = instr[RS1_MSB:RS1_LSB];
    d.rs2       = instr[RS2_MSB:RS2_LSB];
    d.imm       = {{20{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
    case (instr[OPC_MSB:OPC_LSB])
      OPC_OP: begin
        d.reads_rs2 = 1'b1;
        d.op        = alu_op_of(f3, instr[ALT_BIT]);
        d.legal     = (f7 == F7_BASE) ||
                      ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        d.op = alu_op_of(f3, (f3 == 3'b101) && instr[ALT_BIT]);
        if (f3 == 3'b101) begin
          d.legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        end else if (f3 == 3'b001) begin
          d.legal = (f7 == F7_BASE);
        end else begin
          d.legal = 1'b1;
        end
      end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port, asynchronous reset to RF_RESET_VAL; x0 reads as zero and ignores writes.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RF_RESET_VAL = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  reg_addr_t       raddr1_i,
  output logic [XLEN-1:0] rdata1_o,
  input  reg_addr_t       raddr2_i,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  reg_addr_t       waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [32];

  // Storage array; entry 0 is kept but never exposed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= RF_RESET_VAL;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? {XLEN{1'b0}} : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? {XLEN{1'b0}} : regs_q[raddr2_i];

endmodule

// File: rtl/alu_issue.sv
// Issue/operand stage feeding a registered ALU, with one-cycle RAW stall and
// writeback forwarding. Define ALU_ISSUE_ILLEGAL_EN to add the 'illegal' pulse output.
module alu_issue
  import alu_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RF_RESET_VAL = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_rd,
  output logic            retire_valid,
  output logic [4:0]      retire_addr,
  output logic [XLEN-1:0] retire_data
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  dec_t            dec_s;
  logic            hazard_s;
  logic            accept_s;
  logic            fwd1_s;
  logic            fwd2_s;
  logic [XLEN-1:0] rf_rdata1_s;
  logic [XLEN-1:0] rf_rdata2_s;
  logic [XLEN-1:0] src1_s;
  logic [XLEN-1:0] src2_s;

  logic            e_valid_q, e_valid_d;
  reg_addr_t       e_rd_q, e_rd_d;
  logic [XLEN-1:0] alu_rs1_q, alu_rs1_d;
  logic [XLEN-1:0] alu_rs2_q, alu_rs2_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            w_valid_q;
  reg_addr_t       w_rd_q;

  assign dec_s = decode_instr(in_instr);

  alu_regfile #(
    .XLEN         (XLEN),
    .RF_RESET_VAL (RF_RESET_VAL)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .raddr1_i (dec_s.rs1),
    .rdata1_o (rf_rdata1_s),
    .raddr2_i (dec_s.rs2),
    .rdata2_o (rf_rdata2_s),
    .we_i     (w_valid_q),
    .waddr_i  (w_rd_q),
    .wdata_i  (alu_rd)
  );

  // The E-stage producer's result only exists once it reaches W, so a consumer
  // waits one cycle and then picks the value off alu_rd.
  always_comb begin
    hazard_s  = 1'b0;
    fwd1_s    = 1'b0;
    fwd2_s    = 1'b0;
    e_valid_d = 1'b0;
    e_rd_d    = e_rd_q;
    alu_rs1_d = alu_rs1_q;
    alu_rs2_d = alu_rs2_q;
    alu_op_d  = alu_op_q;

    if (in_valid && dec_s.legal && e_valid_q && (e_rd_q != 5'd0)) begin
      hazard_s = (dec_s.rs1 == e_rd_q) || (dec_s.reads_rs2 && (dec_s.rs2 == e_rd_q));
    end else begin
      hazard_s = 1'b0;
    end

    if (w_valid_q && (w_rd_q != 5'd0)) begin
      fwd1_s = (dec_s.rs1 == w_rd_q);
      fwd2_s = (dec_s.rs2 == w_rd_q);
    end else begin
      fwd1_s = 1'b0;
      fwd2_s = 1'b0;
    end

    src1_s   = fwd1_s ? alu_rd : rf_rdata1_s;
    src2_s   = fwd2_s ? alu_rd : rf_rdata2_s;
    accept_s = in_valid && !hazard_s;

    if (accept_s && dec_s.legal) begin
      e_valid_d = 1'b1;
      e_rd_d    = dec_s.rd;
      alu_rs1_d = src1_s;
      alu_rs2_d = dec_s.reads_rs2 ? src2_s : dec_s.imm;
      alu_op_d  = dec_s.op;
    end else begin
      e_valid_d = 1'b0;
    end
  end

  // E and W stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_q <= 1'b0;
      e_rd_q    <= 5'd0;
      alu_rs1_q <= {XLEN{1'b0}};
      alu_rs2_q <= {XLEN{1'b0}};
      alu_op_q  <= 4'd0;
      w_valid_q <= 1'b0;
      w_rd_q    <= 5'd0;
    end else begin
      e_valid_q <= e_valid_d;
      e_rd_q    <= e_rd_d;
      alu_rs1_q <= alu_rs1_d;
      alu_rs2_q <= alu_rs2_d;
      alu_op_q  <= alu_op_d;
      w_valid_q <= e_valid_q;
      w_rd_q    <= e_rd_q;
    end
  end

  assign in_ready     = !hazard_s;
  assign alu_rs1      = alu_rs1_q;
  assign alu_rs2      = alu_rs2_q;
  assign alu_op       = alu_op_q;
  assign retire_valid = w_valid_q;
  assign retire_addr  = w_rd_q;
  assign retire_data  = alu_rd;

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic illegal_q;

  // One-cycle flag for an accepted instruction that decode rejected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept_s && !dec_s.legal;
    end
  end

  assign illegal = illegal_q;
`endif

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue/operand stage directly upstream of the registered 32-bit ALU.
- Decodes RV32I OP/OP-IMM instructions and reads a 32x32 register file.
- Drives registered rs1/rs2/op to the ALU and writes the ALU result back one cycle after the ALU captures it.
- Handles the read-after-write hazard with one stall cycle plus forwarding from the writeback slot.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RF_RESET_VAL, 32'h0, value loaded into x1..x31 on reset.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready at posedge clk
- in_instr  in  32  RV32I instruction word
- alu_rs1  out  32  ALU operand 1, registered
- alu_rs2  out  32  ALU operand 2 or sign-extended immediate, registered
- alu_op  out  4  ALU opcode, registered
- alu_rd  in  32  registered ALU result, valid in the cycle after operands are presented
- retire_valid  out  1  writeback slot holds a valid instruction
- retire_addr  out  5  destination register of the retiring instruction
- retire_data  out  32  result being written (equals alu_rd)

Behaviour:
- Clock and reset: clk, rising edge. reset is asynchronous, active-high.
- Reset values:
  - alu_rs1, alu_rs2, alu_op = 0; all RF entries = RF_RESET_VAL (x0 always reads 0).
  - E and W stage valids = 0, so retire_valid = 0 and in_ready = 1.
- Pipeline:
  - E stage = values on the alu_* outputs.
  - W stage = ALU output.
  - Accepted at edge T: alu_* update at T; ALU captures at T+1; retire_valid high during cycle T+1..T+2; RF written at edge T+2.
  - Throughput: one instruction per cycle when there is no hazard.
- Decode, op = {bit30-qualifier, funct3}:
  - OP (0110011): op = {instr[30], funct3}; operand 2 = RF[rs2].
  - OP-IMM (0010011): operand 2 = sign-extended instr[31:20]. op = {instr[30], funct3} when funct3 == 101, else {0, funct3}.
  - Resulting encodings: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111.
  - Any other opcode: accepted and treated as a bubble. E valid = 0, alu_* hold, no retire.
- Bubbles: when in_valid = 0 or on a stall, E valid = 0 and alu_* hold their value. The ALU result for that slot is ignored.
- Hazard / stall:
  - Condition: in_valid && E valid && E rd != 0 && the decoded instruction reads E rd. rs1 always counts; rs2 counts only for OP.
  - Response: in_ready = 0 (combinational) and a bubble is inserted.
  - in_instr must be held stable by the source while stalled.
- Forwarding: if a source register equals W rd (W valid, rd != 0), the operand is taken from alu_rd instead of the RF.
- Writeback:
  - Writes with rd == 0 still retire (retire_valid = 1) but do not modify x0.
  - Reads of x0 return 0 and never cause a stall or forward.
- Reset mid-operation clears E/W valids immediately. In-flight instructions are discarded and never retire.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_EN.
- Defined: adds output port illegal (1 bit), registered, reset 0. It pulses high for one cycle after a handshake on an unsupported opcode, or on OP-IMM shift/OP with invalid funct7. Such instructions still become bubbles.
- Undefined: port absent; unsupported instructions are silently dropped.

Decomposition:
- Package alu_pkg:
  - opcode constants OPC_OP, OPC_OP_IMM;
  - 4-bit ALU op constants (ALU_ADD..ALU_AND, matching the encodings above);
  - instruction field bit positions;
  - typedef for the 5-bit register address.
- Sub-module alu_regfile: 32x32, 2 async read ports, 1 sync write port, async reset to RF_RESET_VAL, x0 hardwired 0. Hazard detection and forwarding stay in alu_issue.

Test Plan:
- Reset then ADDI x1,x0,5 (0x00500093) -> alu_op=0000, alu_rs2=5; two cycles later retire_valid=1, retire_addr=1, retire_data=5.
- ADDI x1,x0,5 then ADDI x2,x0,-3 (0xFFD00113) then ADD x3,x1,x2 (0x002081B3) back-to-back -> in_ready=0 for exactly one cycle on the ADD; x3 retires 32'h00000002 via forwarding.
- SUB x4,x1,x2 (0x40208233) with no hazard -> alu_op=1000, retire_data=32'h00000008, no stall.
- SRAI x5,x2,1 (0x40115293) -> alu_op=1101, alu_rs2=32'h00000401, retire_data=32'hFFFFFFFE.
- ADDI x0,x0,7 (0x00700013) then ADD x6,x0,x0 -> first retires with data 7; x6 = 0; no stall.
- Reset asserted while an instruction is in E -> retire_valid stays 0 and in_ready=1 after reset. With ALU_ISSUE_ILLEGAL_EN, instr 0x00000003 -> illegal pulses 1 cycle and there is no retire.
